alu_sequencer: RTL and testbench

Sequences 12-bit commands through the shared ALU. It owns the 8-entry x 32-bit operand register file, decodes each command, reads the operands and issues them to the ALU over a valid/ready handshake. It then waits for the result, with a timeout, and writes the result back to the destination register. The block sits between the command source (host or test sequencer) and the ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, command layout and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100,
      OP_NOP = 3'b111
   } opcode_t;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] dest;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WB,
      DONE
   } state_t;

   // Opcodes 101, 110 and 111 retire without touching the ALU.
   function automatic logic is_nop(input logic [2:0] op);
      return op[2] & (op[1] | op[0]);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: one synchronous write port, three asynchronous read ports,
// cleared to zero by reset.
module alu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [AW-1:0]     raddr_h,
   output logic [DATA_W-1:0] rdata_h
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
   assign rdata_h = regs[raddr_h];

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer for the shared ALU: decodes 12-bit commands, issues operands from
// the local register file, waits for the result with a timeout and writes it back.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NREGS   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [11:0]       cmd,
   input  logic              host_we,
   input  logic [2:0]        host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              alu_valid,
   input  logic              alu_ready,
   output logic [2:0]        alu_op_code,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic              alu_res_valid,
   input  logic [DATA_W-1:0] alu_result,
   output logic              done,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            next_state;
   logic              timeout_hit;
   cmd_t              cmd_f;
   logic              accept;
   logic              host_wr;
   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic              rf_we;
   logic [2:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [2:0]        op_q;
   logic [2:0]        dest_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] result_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              err_q;

   assign cmd_f   = cmd_t'(cmd);
   assign accept  = (state == IDLE) && cmd_valid;
   assign host_wr = (state == IDLE) && host_we;

   // A host write landing in the accept cycle must be visible to the operands it targets.
   assign opnd_a = (host_wr && (host_addr == cmd_f.a)) ? host_wdata : rf_a;
   assign opnd_b = (host_wr && (host_addr == cmd_f.b)) ? host_wdata : rf_b;

   // Host writes only happen in IDLE and writeback only in WB, so one port suffices.
   assign rf_we    = host_wr || (state == WB);
   assign rf_waddr = (state == WB) ? dest_q : host_addr;
   assign rf_wdata = (state == WB) ? result_q : host_wdata;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (3)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (cmd_f.a),
      .rdata_a (rf_a),
      .raddr_b (cmd_f.b),
      .rdata_b (rf_b),
      .raddr_h (host_addr),
      .rdata_h (host_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               next_state = is_nop(cmd_f.op) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (alu_ready) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (alu_res_valid) begin
               next_state = WB;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               next_state  = DONE;
               timeout_hit = 1'b1;
            end
         end
         WB:      next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operands are latched on accept and held untouched until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_NOP;
         dest_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_q   <= cmd_f.op;
            dest_q <= cmd_f.dest;
            a_q    <= opnd_a;
            b_q    <= (cmd_f.op == OP_NOT) ? '0 : opnd_b;
         end
         if ((state == ISSUE) && alu_ready) begin
            cnt_q <= '0;
         end else if (state == WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if ((state == WAIT) && alu_res_valid) begin
            result_q <= alu_result;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign cmd_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign alu_valid   = (state == ISSUE);
   assign done        = (state == DONE);
   assign alu_op_code = op_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU whose response delay
// can be stretched or suppressed.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [11:0] cmd = '0;
   logic        host_we = 1'b0;
   logic [2:0]  host_addr = '0;
   logic [31:0] host_wdata = '0;
   logic [31:0] host_rdata;
   logic        alu_valid;
   logic        alu_ready = 1'b1;
   logic [2:0]  alu_op_code;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_res_valid;
   logic [31:0] alu_result;
   logic        done;
   logic        busy;
   logic        err;

   int          nAsserts = 0;
   int          nFails = 0;
   int          cycles;
   logic        aluMute = 1'b0;
   int          aluDelay = 1;
   int          pendCnt;
   logic [31:0] pendRes;

   always #5 clk = ~clk;

   alu_sequencer #(
      .DATA_W  (32),
      .NREGS   (8),
      .TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd           (cmd),
      .host_we       (host_we),
      .host_addr     (host_addr),
      .host_wdata    (host_wdata),
      .host_rdata    (host_rdata),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_op_code   (alu_op_code),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_res_valid (alu_res_valid),
      .alu_result    (alu_result),
      .done          (done),
      .busy          (busy),
      .err           (err)
   );

   function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return ~a;
         default: return 32'h0;
      endcase
   endfunction

   // Behavioural ALU: a delay of d puts the result strobe in the d-th cycle after the handshake.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_valid <= 1'b0;
         alu_result    <= '0;
         pendCnt       <= 0;
         pendRes       <= '0;
      end else begin
         alu_res_valid <= 1'b0;
         if (pendCnt != 0) begin
            pendCnt <= pendCnt - 1;
            if (pendCnt == 1) begin
               alu_res_valid <= 1'b1;
               alu_result    <= pendRes;
            end
         end
         if (alu_valid && alu_ready && !aluMute) begin
            if (aluDelay <= 1) begin
               alu_res_valid <= 1'b1;
               alu_result    <= aluModel(alu_op_code, alu_a, alu_b);
            end else begin
               pendCnt <= aluDelay - 1;
               pendRes <= aluModel(alu_op_code, alu_a, alu_b);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkFlag(input string tag, input logic observed, input logic expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkReg(input string tag, input logic [2:0] addr, input logic [31:0] expected);
      host_addr = addr;
      #1;
      checkOutput(tag, host_rdata, expected);
   endtask

   task automatic hostWrite(input logic [2:0] addr, input logic [31:0] data);
      host_we    = 1'b1;
      host_addr  = addr;
      host_wdata = data;
      tick();
      host_we = 1'b0;
   endtask

   // Offers one command (optionally with a same-cycle host write) across the accept edge.
   task automatic applyStimulus(input logic [11:0] cmdWord, input logic hostWe,
                                input logic [2:0] hostAddr, input logic [31:0] hostData);
      checkFlag("cmdReadyBeforeAccept", cmd_ready, 1'b1);
      cmd_valid  = 1'b1;
      cmd        = cmdWord;
      host_we    = hostWe;
      host_addr  = hostAddr;
      host_wdata = hostData;
      tick();
      cmd_valid = 1'b0;
      host_we   = 1'b0;
   endtask

   // Cycles are counted from the accept cycle: the cycle right after it is 1.
   task automatic waitDone(input int limit, output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < limit) begin
         tick();
         lat++;
      end
      if (done !== 1'b1) begin
         checkFlag("doneWithinBound", done, 1'b1);
      end
      tick();
      checkFlag("donePulseEnds", done, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      checkFlag("rstCmdReady", cmd_ready, 1'b1);
      checkFlag("rstBusy", busy, 1'b0);
      checkFlag("rstAluValid", alu_valid, 1'b0);
      checkOutput("rstOpCode", {29'b0, alu_op_code}, 32'h7);
      checkOutput("rstAluA", alu_a, 32'h0);
      checkOutput("rstAluB", alu_b, 32'h0);
      checkFlag("rstDone", done, 1'b0);
      checkFlag("rstErr", err, 1'b0);
      rst = 1'b0;
      tick();

      // ADD r3 = r1 + r2
      hostWrite(3'd1, 32'd5);
      hostWrite(3'd2, 32'd3);
      checkReg("hostRead1", 3'd1, 32'd5);
      applyStimulus(12'b000_001_010_011, 1'b0, 3'd0, 32'h0);
      checkFlag("addAluValid", alu_valid, 1'b1);
      checkOutput("addAluA", alu_a, 32'd5);
      checkOutput("addAluB", alu_b, 32'd3);
      checkOutput("addOp", {29'b0, alu_op_code}, 32'h0);
      checkFlag("addCmdReady", cmd_ready, 1'b0);
      checkFlag("addBusy", busy, 1'b1);
      waitDone(20, cycles);
      checkOutput("addLatency", cycles, 32'd4);
      checkReg("addResult", 3'd3, 32'd8);

      // NOT r4 = ~r1, operand B forced to zero even though r0 is nonzero
      hostWrite(3'd0, 32'h0000_1234);
      hostWrite(3'd1, 32'h0000_FFFF);
      applyStimulus(12'b100_001_000_100, 1'b0, 3'd0, 32'h0);
      checkOutput("notAluA", alu_a, 32'h0000_FFFF);
      checkOutput("notAluB", alu_b, 32'h0);
      checkOutput("notOp", {29'b0, alu_op_code}, 32'h4);
      waitDone(20, cycles);
      checkOutput("notLatency", cycles, 32'd4);
      checkReg("notResult", 3'd4, 32'hFFFF_0000);

      // NOP retires in one cycle without touching the ALU
      applyStimulus(12'b111_001_010_011, 1'b0, 3'd0, 32'h0);
      checkFlag("nopAluValid", alu_valid, 1'b0);
      checkFlag("nopBusy", busy, 1'b1);
      waitDone(20, cycles);
      checkOutput("nopLatency", cycles, 32'd1);
      checkReg("nopRfUnchanged", 3'd3, 32'd8);

      // Same-cycle host write to both source registers is bypassed into the operands
      applyStimulus(12'b000_101_101_110, 1'b1, 3'd5, 32'd7);
      checkOutput("bypassAluA", alu_a, 32'd7);
      checkOutput("bypassAluB", alu_b, 32'd7);
      waitDone(20, cycles);
      checkReg("bypassResult", 3'd6, 32'd14);
      checkReg("bypassHostWrite", 3'd5, 32'd7);

      // SUB with ALU stalled for 10 cycles; host writes during the stall are dropped
      alu_ready = 1'b0;
      applyStimulus(12'b001_001_010_111, 1'b0, 3'd0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         host_we    = 1'b1;
         host_addr  = 3'd0;
         host_wdata = 32'hDEAD_BEEF;
         checkFlag("stallAluValid", alu_valid, 1'b1);
         checkOutput("stallAluA", alu_a, 32'h0000_FFFF);
         checkOutput("stallAluB", alu_b, 32'd3);
         checkFlag("stallCmdReady", cmd_ready, 1'b0);
         tick();
      end
      host_we   = 1'b0;
      alu_ready = 1'b1;
      waitDone(20, cycles);
      checkReg("stallResult", 3'd7, 32'h0000_FFFC);
      checkReg("stallHostIgnored", 3'd0, 32'h0000_1234);

      // Result arriving in the last WAIT cycle still wins over the timeout
      aluDelay = 16;
      applyStimulus(12'b011_001_010_101, 1'b0, 3'd0, 32'h0);
      waitDone(40, cycles);
      checkOutput("lateLatency", cycles, 32'd19);
      checkFlag("lateNoErr", err, 1'b0);
      checkReg("lateResult", 3'd5, 32'h0000_FFFF);
      aluDelay = 1;

      // ALU never answers: timeout after 16 WAIT cycles, no writeback
      aluMute = 1'b1;
      applyStimulus(12'b011_001_010_011, 1'b0, 3'd0, 32'h0);
      waitDone(40, cycles);
      checkOutput("timeoutLatency", cycles, 32'd18);
      checkFlag("timeoutErr", err, 1'b1);
      checkReg("timeoutNoWb", 3'd3, 32'd8);
      aluMute = 1'b0;

      // Following command still runs; err stays sticky
      applyStimulus(12'b010_001_010_000, 1'b0, 3'd0, 32'h0);
      waitDone(20, cycles);
      checkOutput("afterTimeoutLatency", cycles, 32'd4);
      checkReg("afterTimeoutResult", 3'd0, 32'd3);
      checkFlag("errSticky", err, 1'b1);

      // Reset while parked in WAIT aborts everything and clears the register file
      aluMute = 1'b1;
      applyStimulus(12'b000_001_010_011, 1'b0, 3'd0, 32'h0);
      tick();
      tick();
      checkFlag("waitBusy", busy, 1'b1);
      checkFlag("waitAluValid", alu_valid, 1'b0);
      rst = 1'b1;
      #1;
      checkFlag("midRstBusy", busy, 1'b0);
      checkFlag("midRstCmdReady", cmd_ready, 1'b1);
      checkFlag("midRstDone", done, 1'b0);
      checkFlag("midRstErr", err, 1'b0);
      checkOutput("midRstOpCode", {29'b0, alu_op_code}, 32'h7);
      checkOutput("midRstAluA", alu_a, 32'h0);
      checkOutput("midRstAluB", alu_b, 32'h0);
      checkReg("midRstRf1", 3'd1, 32'h0);
      checkReg("midRstRf3", 3'd3, 32'h0);
      rst     = 1'b0;
      aluMute = 1'b0;
      tick();

      hostWrite(3'd1, 32'd100);
      hostWrite(3'd2, 32'd23);
      applyStimulus(12'b000_001_010_011, 1'b0, 3'd0, 32'h0);
      waitDone(20, cycles);
      checkOutput("postRstLatency", cycles, 32'd4);
      checkReg("postRstResult", 3'd3, 32'd123);
      checkFlag("postRstErr", err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
